// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic 10 us trigger, echo timed in us and converted to cm.
// Echo edge reaches the FSM after 2 sync flops + 1 state flop; no backpressure, results are simply overwritten.
module ultrasonic_ranger #(
    parameter int CLK_PER_US      = 50,
    parameter int TRIG_US         = 10,
    parameter int PERIOD_US       = 20000,
    parameter int RISE_TIMEOUT_US = 1000,
    parameter int US_PER_CM       = 58,
    parameter int MAX_CM          = 300
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       ECHO,
    output logic       TRIG,
    output logic [8:0] DIST_CM,
    output logic       VALID,
    output logic       OOR,
    output logic       NO_ECHO
);

    localparam int US_MAX = (TRIG_US > RISE_TIMEOUT_US) ? TRIG_US : RISE_TIMEOUT_US;
    localparam int PRE_W  = $clog2(CLK_PER_US + 1);
    localparam int PER_W  = $clog2(PERIOD_US + 1);
    localparam int US_W   = $clog2(US_MAX + 1);
    localparam int SUB_W  = $clog2(US_PER_CM + 1);

    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(CLK_PER_US - 1);
    localparam logic [PER_W-1:0] PER_LAST   = PER_W'(PERIOD_US - 1);
    localparam logic [US_W-1:0]  TRIG_LAST  = US_W'(TRIG_US - 1);
    localparam logic [US_W-1:0]  RISE_LAST  = US_W'(RISE_TIMEOUT_US - 1);
    localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(US_PER_CM - 1);
    localparam logic [8:0]       CM_MAX     = 9'(MAX_CM);
    localparam logic [9:0]       CM_MAX_W   = 10'(MAX_CM);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TRIG = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_MEAS = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic             echo_meta_q, echo_s_q;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [2:0]       state_q, state_d;
    logic [US_W-1:0]  us_q, us_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [8:0]       cm_q, cm_d;
    logic             trig_q, trig_d;
    logic [8:0]       dist_q, dist_d;
    logic             oor_q, oor_d;
    logic             noe_q, noe_d;
    logic             valid_q, valid_d;

    logic             us_tick;
    logic             start;
    logic             carry;
    logic [9:0]       meas_cm;

    assign us_tick = (pre_q == PRE_LAST);
    assign start   = us_tick && (per_q == PER_LAST);
    assign carry   = us_tick && (sub_q == SUB_LAST);

    always_comb begin
        pre_d = us_tick ? '0 : pre_q + PRE_W'(1);
        per_d = per_q;
        if (us_tick) begin
            per_d = (per_q == PER_LAST) ? '0 : per_q + PER_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        us_d    = us_q;
        sub_d   = sub_q;
        cm_d    = cm_q;
        trig_d  = trig_q;
        dist_d  = dist_q;
        oor_d   = oor_q;
        noe_d   = noe_q;
        valid_d = 1'b0;
        // A microsecond tick landing on the falling-edge cycle still counts,
        // so an echo of N whole microseconds yields exactly N ticks.
        meas_cm = {1'b0, cm_q} + {9'd0, carry};
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    trig_d  = 1'b1;
                    us_d    = '0;
                    state_d = S_TRIG;
                end
            end
            S_TRIG: begin
                if (us_tick) begin
                    if (us_q == TRIG_LAST) begin
                        trig_d  = 1'b0;
                        us_d    = '0;
                        state_d = S_WAIT;
                    end else begin
                        us_d = us_q + US_W'(1);
                    end
                end
            end
            S_WAIT: begin
                if (echo_s_q) begin
                    sub_d   = '0;
                    cm_d    = '0;
                    state_d = S_MEAS;
                end else if (us_tick) begin
                    if (us_q == RISE_LAST) begin
                        noe_d   = 1'b1;
                        oor_d   = 1'b0;
                        dist_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        us_d = us_q + US_W'(1);
                    end
                end
            end
            S_MEAS: begin
                if (!echo_s_q) begin
                    dist_d  = (meas_cm > CM_MAX_W) ? CM_MAX : meas_cm[8:0];
                    oor_d   = 1'b0;
                    noe_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cm_q == CM_MAX) begin
                    dist_d  = CM_MAX;
                    oor_d   = 1'b1;
                    noe_d   = 1'b0;
                    state_d = S_DONE;
                end else if (carry) begin
                    sub_d = '0;
                    cm_d  = cm_q + 9'd1;
                end else if (us_tick) begin
                    sub_d = sub_q + SUB_W'(1);
                end
            end
            S_DONE: begin
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
            pre_q       <= '0;
            per_q       <= '0;
            state_q     <= S_IDLE;
            us_q        <= '0;
            sub_q       <= '0;
            cm_q        <= '0;
            trig_q      <= 1'b0;
            dist_q      <= '0;
            oor_q       <= 1'b0;
            noe_q       <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            echo_meta_q <= ECHO;
            echo_s_q    <= echo_meta_q;
            pre_q       <= pre_d;
            per_q       <= per_d;
            state_q     <= state_d;
            us_q        <= us_d;
            sub_q       <= sub_d;
            cm_q        <= cm_d;
            trig_q      <= trig_d;
            dist_q      <= dist_d;
            oor_q       <= oor_d;
            noe_q       <= noe_d;
            valid_q     <= valid_d;
        end
    end

    assign TRIG    = trig_q;
    assign DIST_CM = dist_q;
    assign VALID   = valid_q;
    assign OOR     = oor_q;
    assign NO_ECHO = noe_q;

endmodule

// File: doc/ultrasonic_ranger.md
# ultrasonic_ranger

Drives an HC-SR04-style ultrasonic sensor: every measurement period it emits a 10 us trigger pulse, times the returned echo pulse, and publishes the distance in centimetres. It consumes the raw 50 MHz system clock directly and derives its own microsecond and period timebase, so the ranging path needs no separate divided clocks. Its output feeds the obstacle-avoidance logic as a registered distance with a one-cycle valid strobe.

## Interface
- CLK_PER_US, 50: system clocks per microsecond.
- TRIG_US, 10: trigger pulse width in us.
- PERIOD_US, 20000: measurement period in us.
- RISE_TIMEOUT_US, 1000: maximum wait from trigger end to echo rise.
- US_PER_CM, 58: echo microseconds per centimetre.
- MAX_CM, 300: saturation distance. Must satisfy TRIG_US + RISE_TIMEOUT_US + MAX_CM*US_PER_CM + 2 < PERIOD_US.
- CLK  input  1  system clock, 50 MHz.
- RST_N  input  1  asynchronous active-low reset.
- ECHO  input  1  sensor echo, asynchronous to CLK.
- TRIG  output  1  sensor trigger, registered.
- DIST_CM  output  9  last measured distance, held between updates.
- VALID  output  1  one-cycle strobe when DIST_CM/OOR/NO_ECHO update.
- OOR  output  1  last result saturated at MAX_CM.
- NO_ECHO  output  1  last cycle saw no echo rise within RISE_TIMEOUT_US.

## Operation
- Reset (RST_N low, asynchronous): TRIG=0, DIST_CM=0, VALID=0, OOR=0, NO_ECHO=0, FSM=IDLE, all counters 0, synchroniser flops 0.
- ECHO passes a 2-flop synchroniser; all FSM decisions use the synchronised level (echo_s).
- us_tick: prescaler counts 0..CLK_PER_US-1; us_tick high for the one cycle where it equals CLK_PER_US-1, then the prescaler wraps to 0.
- Period counter: free-running in us, counts 0..PERIOD_US-1 on us_tick. A start pulse is generated on the us_tick where it wraps to 0.
- FSM states:
  - IDLE: on start, set TRIG=1, clear us count, go to TRIG. Start is ignored in any other state; this cannot occur with a legal parameter set.
  - TRIG: count us_ticks; when TRIG_US ticks have elapsed, set TRIG=0 and go to WAIT_RISE.
  - WAIT_RISE: echo_s=1 goes to MEASURE with the sub-counter and cm counter cleared. If RISE_TIMEOUT_US us_ticks elapse with no rise, set NO_ECHO=1, OOR=0, and DIST_CM=0, then go to DONE.
  - MEASURE: on each us_tick, increment the sub-counter; when the sub-counter reaches US_PER_CM-1, wrap it to 0 and increment the cm counter. On echo_s falling, latch DIST_CM=cm counter, OOR=0, NO_ECHO=0, then go to DONE. If the cm counter reaches MAX_CM while echo_s is still high, latch DIST_CM=MAX_CM, OOR=1, and go to DONE.
  - DONE: VALID=1 for exactly one cycle, then IDLE. DONE is skipped as a separate wait; it lasts one cycle.
- Partial centimetres are truncated: floor(echo_us / US_PER_CM).
- After saturation, any remaining echo high time is ignored. The next cycle starts only on the next period start.
- Echo high during TRIG or IDLE is ignored, with no state change.
- Echo already high on entry to WAIT_RISE is treated as a rise on the first WAIT_RISE cycle.

## Timing
- Trigger: TRIG rises 1 CLK after the start us_tick and is high for exactly TRIG_US*CLK_PER_US cycles (500 by default).
- Echo edge to FSM: 2 CLK of synchroniser latency plus 1 CLK of registered state.
- VALID asserts 1 CLK after the DONE transition. DIST_CM, OOR, and NO_ECHO are stable in the VALID cycle and hold until the next VALID.
- Measurement resolution is ±1 us, due to prescaler phase, plus 3 CLK of synchroniser and edge latency. The spec tolerance is ±1 cm.
- Asserting RST_N low mid-measurement aborts the measurement immediately, and all outputs take their reset values. After release, the first trigger occurs at the first period wrap, PERIOD_US us later.

## Test plan
- Reset release, ECHO=0: first TRIG rises 20000 us after reset release, is high for 500 CLK, and repeats every 1,000,000 CLK.
- ECHO rises 400 us after TRIG falls and stays high 580 us: VALID pulses once with DIST_CM=10, OOR=0, NO_ECHO=0. Also check ECHO high 1159 us -> DIST_CM=19.
- ECHO never rises: VALID occurs 1000 us after TRIG falls, with NO_ECHO=1, DIST_CM=0, OOR=0.
- ECHO high 25 ms: VALID occurs after 17400 us of echo, with DIST_CM=300 and OOR=1. The next cycle still triggers on schedule.
- ECHO pulses high during TRIG, then low: ignored, with no early VALID. A proper echo after that is measured normally.
- RST_N asserted mid-MEASURE, 300 us into the echo: TRIG=0, DIST_CM=0, and VALID=0 immediately. No VALID until a full new cycle completes after release.
